rename_unit: RTL

- Register rename stage between decode and the 64-entry physical register file.
- Translates 5-bit architectural source and destination addresses into 6-bit physical tags.
- Allocates a fresh physical register for every renamed destination and returns old mappings to the free pool when the ROB commits.
- Keeps a speculative map and a committed map; a flush restores speculative state from committed state in one cycle.

---
 rtl/rename_if.sv | 39 +++
 rtl/rename_unit.sv | 111 +++++++++++
 2 files changed

// File: rtl/rename_if.sv
// Rename stage bus: decode-side rename request/response, ROB commit port,
// flush and the speculative free count.
interface rename_if #(
    parameter int AW = 5,
    parameter int PW = 6
);
    logic          ren_valid;
    logic          ren_ready;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic          uses_rs;
    logic          uses_rt;
    logic [AW-1:0] rw_addr;
    logic          uses_rw;
    logic [PW-1:0] rs_phy;
    logic [PW-1:0] rt_phy;
    logic [PW-1:0] rw_phy;
    logic [PW-1:0] rw_old_phy;
    logic          commit_valid;
    logic [AW-1:0] commit_arch;
    logic [PW-1:0] commit_phy;
    logic [PW-1:0] commit_old_phy;
    logic          flush;
    logic [PW:0]   free_count;

    // Decode/ROB side
    modport master (
        output ren_valid, rs_addr, rt_addr, uses_rs, uses_rt, rw_addr, uses_rw,
               commit_valid, commit_arch, commit_phy, commit_old_phy, flush,
        input  ren_ready, rs_phy, rt_phy, rw_phy, rw_old_phy, free_count
    );

    // Rename unit side
    modport slave (
        input  ren_valid, rs_addr, rt_addr, uses_rs, uses_rt, rw_addr, uses_rw,
               commit_valid, commit_arch, commit_phy, commit_old_phy, flush,
        output ren_ready, rs_phy, rt_phy, rw_phy, rw_old_phy, free_count
    );
endinterface

// File: rtl/rename_unit.sv
// Register rename: speculative and committed map tables plus free bitmaps.
// Lookups are combinational from the speculative map; allocation takes the
// lowest free physical tag; flush copies committed state over speculative
// state (including a same-cycle commit) in one cycle.
module rename_unit #(
    parameter int ARCH_REGS = 32,
    parameter int PHY_REGS  = 64
) (
    input logic    clk,
    input logic    rst_n,
    rename_if.slave rif
);
    localparam int PW = $clog2(PHY_REGS);
    localparam int CW = PW + 1;

    logic [PW-1:0]       spec_map     [ARCH_REGS];
    logic [PW-1:0]       arch_map     [ARCH_REGS];
    logic [PW-1:0]       spec_map_nxt [ARCH_REGS];
    logic [PW-1:0]       arch_map_nxt [ARCH_REGS];
    logic [PHY_REGS-1:0] spec_free, arch_free;
    logic [PHY_REGS-1:0] spec_free_nxt, arch_free_nxt;
    logic [CW-1:0]       free_cnt_q, free_cnt_nxt;

    logic [PW-1:0] alloc_idx;
    logic          any_free;
    logic          alloc_need;
    logic          fire_alloc;

    // Priority encoder: lowest set bit of the speculative free map
    always_comb begin
        alloc_idx = '0;
        for (int i = PHY_REGS - 1; i >= 0; i--) begin
            if (spec_free[i]) alloc_idx = PW'(i);
        end
    end

    assign any_free   = |spec_free;
    // Arch reg 0 is hardwired to phys 0 and never takes a new tag
    assign alloc_need = rif.uses_rw && (rif.rw_addr != '0);
    assign fire_alloc = rif.ren_valid && rif.ren_ready && alloc_need;

    // Combinational lookup from the pre-update speculative map
    always_comb begin
        rif.rs_phy     = rif.uses_rs ? spec_map[rif.rs_addr] : '0;
        rif.rt_phy     = rif.uses_rt ? spec_map[rif.rt_addr] : '0;
        rif.rw_old_phy = spec_map[rif.rw_addr];
        rif.rw_phy     = alloc_need ? alloc_idx : '0;
        rif.ren_ready  = !rif.flush && (any_free || !alloc_need);
        rif.free_count = free_cnt_q;
    end

    // Committed state update from the ROB retire port
    always_comb begin
        arch_map_nxt  = arch_map;
        arch_free_nxt = arch_free;
        if (rif.commit_valid) begin
            if (rif.commit_arch != '0)
                arch_map_nxt[rif.commit_arch] = rif.commit_phy;
            if (rif.commit_phy != '0)
                arch_free_nxt[rif.commit_phy] = 1'b0;
            if (rif.commit_old_phy != '0)
                arch_free_nxt[rif.commit_old_phy] = 1'b1;
        end
    end

    // Speculative state: flush restore wins, else rename alloc plus commit release.
    // The released tag was not free this cycle, so it never equals alloc_idx.
    always_comb begin
        spec_map_nxt  = spec_map;
        spec_free_nxt = spec_free;
        if (rif.flush) begin
            spec_map_nxt  = arch_map_nxt;
            spec_free_nxt = arch_free_nxt;
        end else begin
            if (rif.commit_valid && (rif.commit_old_phy != '0))
                spec_free_nxt[rif.commit_old_phy] = 1'b1;
            if (fire_alloc) begin
                spec_map_nxt[rif.rw_addr] = alloc_idx;
                spec_free_nxt[alloc_idx]  = 1'b0;
            end
        end
    end

    // Free count tracks the next free map so it is registered alongside it
    always_comb begin
        free_cnt_nxt = '0;
        for (int i = 0; i < PHY_REGS; i++)
            free_cnt_nxt = free_cnt_nxt + CW'(spec_free_nxt[i]);
    end

    // State registers; reset maps arch i to phys i, upper tags free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                spec_map[i] <= PW'(i);
                arch_map[i] <= PW'(i);
            end
            for (int i = 0; i < PHY_REGS; i++) begin
                spec_free[i] <= (i >= ARCH_REGS);
                arch_free[i] <= (i >= ARCH_REGS);
            end
            free_cnt_q <= CW'(PHY_REGS - ARCH_REGS);
        end else begin
            spec_map   <= spec_map_nxt;
            arch_map   <= arch_map_nxt;
            spec_free  <= spec_free_nxt;
            arch_free  <= arch_free_nxt;
            free_cnt_q <= free_cnt_nxt;
        end
    end
endmodule
